// File: rtl/reg_display_sched_if.sv
// Bus bundle between the register display sequencer, the cpu regfile port and a vram_muxer
// writer slot. master is the sequencer side, slave is the cpu/muxer side.
interface reg_display_sched_if;
    logic         start;
    logic         busy;
    logic         done;
    logic         regfile_request;
    logic [3:0]   regfile_ra;
    logic         regfile_grant;
    logic [15:0]  regfile_rd;
    logic         activate_write;
    logic         vram_turn;
    logic [8:0]   vram_addr;
    logic [639:0] vram_in;
    logic [639:0] vram_out;
    logic         vram_we;

    modport master (
        input  start,
        output busy,
        output done,
        output regfile_request,
        output regfile_ra,
        input  regfile_grant,
        input  regfile_rd,
        output activate_write,
        input  vram_turn,
        output vram_addr,
        input  vram_in,
        output vram_out,
        output vram_we
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  regfile_request,
        input  regfile_ra,
        output regfile_grant,
        output regfile_rd,
        input  activate_write,
        output vram_turn,
        input  vram_addr,
        output vram_in,
        input  vram_out,
        input  vram_we
    );
endinterface

// File: rtl/reg_display_sched.sv
// Walks R0..R15, fetches each through the regfile port and, when it differs from the shadow
// copy, read-modify-writes that register's band of VRAM lines with a 16-cell bit-map.
module reg_display_sched #(
    parameter int unsigned BASE_LINE     = 64,
    parameter int unsigned LINES_PER_REG = 8,
    parameter int unsigned X_OFFSET      = 256,
    parameter int unsigned VRAM_LAT      = 2
) (
    input logic                  clk,
    input logic                  rst,
    reg_display_sched_if.master  bus
);

    localparam int unsigned LatW = (VRAM_LAT > 1) ? $clog2(VRAM_LAT) : 1;

    typedef enum logic [3:0] {
        StIdle, StRfReq, StRfWait, StCmp, StVrReq, StVrRd, StVrWr, StVrRel, StNext
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [4:0]      k_q, k_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic [15:0]     val_q, val_d;
    logic [639:0]    line_q, line_d;
    logic            grant_q;
    logic [15:0]     shadow_q [16];
    logic [15:0]     shadow_valid_q;
    logic            shadow_we;

    logic [8:0]      line_addr;
    logic [639:0]    line_wr;

    logic            busy, done, regfile_request, activate_write, vram_we;
    logic [3:0]      regfile_ra;
    logic [8:0]      vram_addr;
    logic [639:0]    vram_out;

    assign line_addr = 9'(BASE_LINE + 32'(idx_q) * LINES_PER_REG + 32'(k_q));

    // Cell b is 7 lit columns plus a blank gap column; MSB sits leftmost.
    always_comb begin
        line_wr = line_q;
        for (int b = 0; b < 16; b++) begin
            line_wr[X_OFFSET + (15 - b) * 8 +: 7] = {7{val_q[b]}};
            line_wr[X_OFFSET + (15 - b) * 8 + 7]  = 1'b0;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        k_d             = k_q;
        lat_d           = lat_q;
        val_d           = val_q;
        line_d          = line_q;
        shadow_we       = 1'b0;
        busy            = (state_q != StIdle);
        done            = 1'b0;
        regfile_request = 1'b0;
        regfile_ra      = 4'd0;
        activate_write  = 1'b0;
        vram_addr       = 9'd0;
        vram_out        = '0;
        vram_we         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    idx_d   = 4'd0;
                    k_d     = 5'd0;
                    state_d = StRfReq;
                end
            end
            StRfReq: begin
                regfile_ra      = idx_q;
                regfile_request = 1'b1;
                state_d         = StRfWait;
            end
            StRfWait: begin
                regfile_ra      = idx_q;
                regfile_request = 1'b1;
                // A grant left high from an earlier fetch must not be mistaken for this one.
                if (bus.regfile_grant && !grant_q) begin
                    val_d   = bus.regfile_rd;
                    state_d = StCmp;
                end
            end
            StCmp: begin
                if (shadow_valid_q[idx_q] && (shadow_q[idx_q] == val_q)) begin
                    state_d = StNext;
                end else begin
                    k_d     = 5'd0;
                    state_d = StVrReq;
                end
            end
            StVrReq: begin
                activate_write = 1'b1;
                vram_addr      = line_addr;
                if (bus.vram_turn) begin
                    lat_d   = '0;
                    state_d = StVrRd;
                end
            end
            StVrRd: begin
                activate_write = 1'b1;
                vram_addr      = line_addr;
                if (!bus.vram_turn) begin
                    state_d = StVrReq;
                end else if (lat_q == LatW'(VRAM_LAT - 1)) begin
                    line_d  = bus.vram_in;
                    state_d = StVrWr;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StVrWr: begin
                activate_write = 1'b1;
                vram_addr      = line_addr;
                vram_out       = line_wr;
                if (!bus.vram_turn) begin
                    state_d = StVrReq;
                end else begin
                    vram_we = 1'b1;
                    state_d = StVrRel;
                end
            end
            StVrRel: begin
                // activate_write stays low here so other writers can win the muxer.
                if (k_q == 5'(LINES_PER_REG - 1)) begin
                    shadow_we = 1'b1;
                    state_d   = StNext;
                end else begin
                    k_d     = k_q + 5'd1;
                    state_d = StVrReq;
                end
            end
            StNext: begin
                if (idx_q == 4'd15) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StRfReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            idx_q          <= 4'd0;
            k_q            <= 5'd0;
            lat_q          <= '0;
            val_q          <= 16'd0;
            line_q         <= '0;
            grant_q        <= 1'b0;
            shadow_valid_q <= 16'd0;
            for (int r = 0; r < 16; r++) begin
                shadow_q[r] <= 16'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
            val_q   <= val_d;
            line_q  <= line_d;
            grant_q <= bus.regfile_grant;
            if (shadow_we) begin
                shadow_q[idx_q]       <= val_q;
                shadow_valid_q[idx_q] <= 1'b1;
            end
        end
    end

    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.regfile_request = regfile_request;
    assign bus.regfile_ra      = regfile_ra;
    assign bus.activate_write  = activate_write;
    assign bus.vram_addr       = vram_addr;
    assign bus.vram_out        = vram_out;
    assign bus.vram_we         = vram_we;

endmodule

// File: doc/reg_display_sched.md
# reg_display_sched

Sequencer that copies the CPU register file into VRAM as an on-screen bit-map. On each `start` pulse it walks registers R0–R15. For each register it does three things: fetches the value through the CPU's regfile request/grant port, compares it against a shadow copy, and, if changed, read-modify-writes the register's band of VRAM lines through one `vram_muxer` writer slot. It sits between `cpu` and `vram_muxer`, next to `write_register`.

## Interface
Parameters:
- `BASE_LINE`, 64: first VRAM line of the R0 band.
- `LINES_PER_REG`, 8: VRAM lines per register band. Must be 1..30; R15's band must end below line 480.
- `X_OFFSET`, 256: first line bit (pixel column) of the bit-map. Requires `X_OFFSET`+128 ≤ 640.
- `VRAM_LAT`, 2: cycles from address valid to `vram_in` valid.

Ports:
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a refresh pass. Ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse at the end of a pass.
- `regfile_request` out 1: request to the cpu regfile port.
- `regfile_ra` out 4: register index.
- `regfile_grant` in 1: grant. Only its rising edge is meaningful.
- `regfile_rd` in 16: register data, valid on the grant rising edge.
- `activate_write` out 1: VRAM slot request.
- `vram_turn` in 1: slot grant from `vram_muxer`.
- `vram_addr` out 9: VRAM line address.
- `vram_in` in 640: line read data.
- `vram_out` out 640: line write data.
- `vram_we` out 1: write strobe, one cycle.

## Operation
- States: IDLE, RF_REQ, RF_WAIT, CMP, VR_REQ, VR_RD, VR_WR, VR_REL, NEXT.
- IDLE: on `start`, set reg index i=0 and line counter k=0, then go to RF_REQ.
- RF_REQ: drive `regfile_ra`=i, assert `regfile_request`, go to RF_WAIT.
- RF_WAIT: hold the request until a `grant` rising edge (registered grant 0→1). On that edge, latch `rd` into `val`, drop the request, and go to CMP.
- CMP: if `shadow_valid[i]` is set and `shadow[i]`==`val`, go to NEXT. Otherwise go to VR_REQ with k=0.
- VR_REQ: assert `activate_write`. Drive `vram_addr`=`BASE_LINE`+i*`LINES_PER_REG`+k (9-bit). Wait for `vram_turn`=1.
- VR_RD: with `vram_turn` high, hold the address for `VRAM_LAT` cycles, then capture `vram_in` into `line`.
- VR_WR: drive `vram_out` = `line`, with bits [`X_OFFSET`+(15−b)*8 +: 7] replaced by seven copies of `val[b]` and bit [`X_OFFSET`+(15−b)*8+7] forced to 0 (gap column), for b=15..0. All other bits pass through unchanged. Pulse `vram_we` for one cycle at the same address.
- VR_REL: deassert `activate_write` for exactly one cycle so other writers get a turn.
  - If k<`LINES_PER_REG`−1: k++ and go to VR_REQ.
  - Otherwise: `shadow[i]`=`val`, `shadow_valid[i]`=1, go to NEXT.
- NEXT: if i==15, pulse `done` and go to IDLE. Otherwise i++ and go to RF_REQ.
- If `vram_turn` falls during VR_RD or VR_WR (preempted), the line is abandoned without a write and the FSM returns to VR_REQ for the same k.
- Reset: all outputs 0, state IDLE, `shadow_valid`=0, so the first pass always writes all 16 bands. Reset mid-pass aborts immediately. No partial write is emitted because `vram_we` clears asynchronously.

## Timing
- Regfile fetch: 2 cycles plus the grant wait.
- Per line, uncontended: 1 cycle (VR_REQ with grant present) + `VRAM_LAT` + 1 (VR_WR) + 1 (VR_REL) = `VRAM_LAT`+3. With defaults that is 5 cycles.
- Full uncontended pass with all registers changed and defaults: 16×(2+g+1+8×5+1) cycles, where g is the grant wait.
- Unchanged register: 4+g cycles.
- `vram_we` is asserted only while `vram_turn` is high and `activate_write` is high.
- `busy` is low in the `done` cycle's successor. A `start` coincident with `done` is ignored.

## Test plan
- Reset then `start`: model regfile returns Ri=16'h1000+i with g=2, and VRAM is prefilled with all 1s. Required: 128 writes. In line 64, bits 256..383 equal the 0x1000 pattern (bit 12 cell set, other cells 0, gap bits 0), and bits outside 256..383 stay 1.
- Second `start` with only R5 changed to 16'hFFFF: required exactly 8 writes, to lines 104..111, and `done` one pass later.
- Arbitration: hold `vram_turn` low 20 cycles per request. Required: no `vram_we` while low, and `activate_write` drops for one cycle between lines.
- Preemption: drop `vram_turn` in the VR_RD cycle of line 64. Required: no write to line 64 on that attempt, followed by a retry and exactly one write.
- Reset pulse mid-pass at register 7: outputs go to 0 the same cycle. The next `start` rewrites all 16 bands.
- `start` pulsed while `busy`: no effect, and the pass count stays unchanged.
